// File: rtl/dp_nbuf_rotating_buffer.sv
// dp_nbuf_rotating_buffer: NUM_BUF-deep ring of polyvec RAMs shared by writer, compute and reader roles
module dp_nbuf_rotating_buffer #(
    parameter int COE_WIDTH  = 39,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_LANE   = 24,
    parameter int NUM_BUF    = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_flush,
    input  logic [NUM_LANE-1:0]            i_wr_we,
    input  logic [ADDR_WIDTH*NUM_LANE-1:0] i_wr_addr,
    input  logic [COE_WIDTH*NUM_LANE-1:0]  i_wr_data,
    input  logic                           i_wr_done,
    output logic                           o_wr_ready,
    input  logic [NUM_LANE-1:0]            i_cp_we,
    input  logic [ADDR_WIDTH*NUM_LANE-1:0] i_cp_wraddr,
    input  logic [COE_WIDTH*NUM_LANE-1:0]  i_cp_data,
    input  logic [ADDR_WIDTH*NUM_LANE-1:0] i_cp_rdaddr,
    output logic [COE_WIDTH*NUM_LANE-1:0]  o_cp_data,
    input  logic                           i_cp_done,
    output logic                           o_cp_ready,
    input  logic [ADDR_WIDTH*NUM_LANE-1:0] i_rd_addr,
    output logic [COE_WIDTH*NUM_LANE-1:0]  o_rd_data,
    input  logic                           i_rd_done,
    output logic                           o_rd_ready,
    output logic [3:0]                     o_num_free,
    output logic                           o_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW = $clog2(NUM_BUF);
    localparam int AL = ADDR_WIDTH * NUM_LANE;
    localparam int DL = COE_WIDTH * NUM_LANE;
    localparam logic [1:0] FREE     = 2'd0;
    localparam logic [1:0] FILLED   = 2'd1;
    localparam logic [1:0] COMPUTED = 2'd2;

    logic [NUM_BUF-1:0][1:0] state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, cp_ptr_q, cp_ptr_d, rd_ptr_q, rd_ptr_d;
    logic err_q, err_d;
    logic wr_acc, cp_acc, rd_acc;
    logic [3:0] num_free;
    logic [NUM_BUF-1:0] wr_own, cp_own, rd_own;
    logic [NUM_LANE-1:0] ram_we [NUM_BUF];
    logic [AL-1:0] ram_waddr [NUM_BUF];
    logic [AL-1:0] ram_raddr [NUM_BUF];
    logic [DL-1:0] ram_wdata [NUM_BUF];
    logic [DL-1:0] ram_dout [NUM_BUF];
    logic [PW-1:0] cp_sel_q [RD_LATENCY];
    logic [PW-1:0] cp_sel_d [RD_LATENCY];
    logic [PW-1:0] rd_sel_q [RD_LATENCY];
    logic [PW-1:0] rd_sel_d [RD_LATENCY];
    logic [RD_LATENCY-1:0] cp_vld_q, cp_vld_d, rd_vld_q, rd_vld_d;

    function automatic logic [PW-1:0] ring_next(input logic [PW-1:0] p);
        return (p == PW'(NUM_BUF - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_wr_ready = state_q[wr_ptr_q] == FREE;
    assign o_cp_ready = state_q[cp_ptr_q] == FILLED;
    assign o_rd_ready = state_q[rd_ptr_q] == COMPUTED;
    assign wr_acc = i_wr_done && o_wr_ready;
    assign cp_acc = i_cp_done && o_cp_ready;
    assign rd_acc = i_rd_done && o_rd_ready;
    assign o_err = err_q;
    assign o_num_free = num_free;

    // Advance each role's buffer one step and bump its pointer on an accepted done; flag rejected dones
    always_comb begin
        state_d = state_q;
        if (wr_acc) state_d[wr_ptr_q] = FILLED;
        if (cp_acc) state_d[cp_ptr_q] = COMPUTED;
        if (rd_acc) state_d[rd_ptr_q] = FREE;
        wr_ptr_d = wr_acc ? ring_next(wr_ptr_q) : wr_ptr_q;
        cp_ptr_d = cp_acc ? ring_next(cp_ptr_q) : cp_ptr_q;
        rd_ptr_d = rd_acc ? ring_next(rd_ptr_q) : rd_ptr_q;
        err_d = err_q || (!i_flush && ((i_wr_done && !o_wr_ready) ||
                                       (i_cp_done && !o_cp_ready) ||
                                       (i_rd_done && !o_rd_ready)));
    end

    // Count FREE buffers from the registered ring state
    always_comb begin
        num_free = '0;
        for (int b = 0; b < NUM_BUF; b++) num_free = num_free + 4'(state_q[b] == FREE);
    end

    // Route each role's ports to the buffer it currently owns; non-owned buffers see idle ports
    always_comb begin
        for (int b = 0; b < NUM_BUF; b++) begin
            wr_own[b]    = o_wr_ready && (wr_ptr_q == PW'(b));
            cp_own[b]    = o_cp_ready && (cp_ptr_q == PW'(b));
            rd_own[b]    = o_rd_ready && (rd_ptr_q == PW'(b));
            ram_we[b]    = wr_own[b] ? i_wr_we   : cp_own[b] ? i_cp_we     : '0;
            ram_waddr[b] = wr_own[b] ? i_wr_addr : cp_own[b] ? i_cp_wraddr : '0;
            ram_wdata[b] = wr_own[b] ? i_wr_data : cp_own[b] ? i_cp_data   : '0;
            ram_raddr[b] = cp_own[b] ? i_cp_rdaddr : rd_own[b] ? i_rd_addr : '0;
        end
    end

    // Capture buffer select and valid at address time and delay them alongside the RAM data
    always_comb begin
        cp_sel_d[0] = cp_ptr_q;
        rd_sel_d[0] = rd_ptr_q;
        cp_vld_d[0] = o_cp_ready;
        rd_vld_d[0] = o_rd_ready;
        for (int k = 1; k < RD_LATENCY; k++) begin
            cp_sel_d[k] = cp_sel_q[k-1];
            rd_sel_d[k] = rd_sel_q[k-1];
            cp_vld_d[k] = cp_vld_q[k-1];
            rd_vld_d[k] = rd_vld_q[k-1];
        end
    end

    // Ring state and role pointers; flush clears them like reset
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            state_q  <= '0;
            wr_ptr_q <= '0;
            cp_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            cp_ptr_q <= cp_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Sticky protocol error survives flush and is cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    // Read select pipelines; clearing them drops in-flight reads on reset or flush
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            cp_vld_q <= '0;
            rd_vld_q <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                cp_sel_q[k] <= '0;
                rd_sel_q[k] <= '0;
            end
        end else begin
            cp_vld_q <= cp_vld_d;
            rd_vld_q <= rd_vld_d;
            cp_sel_q <= cp_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    assign o_cp_data = cp_vld_q[RD_LATENCY-1] ? ram_dout[cp_sel_q[RD_LATENCY-1]] : '0;
    assign o_rd_data = rd_vld_q[RD_LATENCY-1] ? ram_dout[rd_sel_q[RD_LATENCY-1]] : '0;

    for (genvar b = 0; b < NUM_BUF; b++) begin : g_buf
        for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
            logic [COE_WIDTH-1:0] mem [DEPTH];
            logic [COE_WIDTH-1:0] pipe_q [RD_LATENCY];
            // Read-first bank: the read sees pre-write contents, then RD_LATENCY-deep output pipeline
            always_ff @(posedge clk) begin
                if (ram_we[b][l]) mem[ram_waddr[b][l*ADDR_WIDTH +: ADDR_WIDTH]] <= ram_wdata[b][l*COE_WIDTH +: COE_WIDTH];
                pipe_q[0] <= mem[ram_raddr[b][l*ADDR_WIDTH +: ADDR_WIDTH]];
                for (int k = 1; k < RD_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
            end
            assign ram_dout[b][l*COE_WIDTH +: COE_WIDTH] = pipe_q[RD_LATENCY-1];
        end
    end
endmodule

// File: tb/tb_dp_nbuf_rotating_buffer.sv
// tb_dp_nbuf_rotating_buffer: directed bench over three ring sizes (3, 4, 5 buffers)
module tb_dp_nbuf_rotating_buffer;
    localparam int CW = 39;
    localparam int AW = 9;
    localparam int NL = 2;
    localparam int RL = 2;
    localparam int AWL = AW * NL;
    localparam int DWL = CW * NL;
    localparam int NV = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           flush [3];
    logic           wr_done [3];
    logic           cp_done [3];
    logic           rd_done [3];
    logic [NL-1:0]  wr_we [3];
    logic [NL-1:0]  cp_we [3];
    logic [AWL-1:0] wr_addr [3];
    logic [AWL-1:0] cp_wraddr [3];
    logic [AWL-1:0] cp_rdaddr [3];
    logic [AWL-1:0] rd_addr [3];
    logic [DWL-1:0] wr_data [3];
    logic [DWL-1:0] cp_din [3];
    logic [DWL-1:0] cp_dout [3];
    logic [DWL-1:0] rd_dout [3];
    logic           wr_rdy [3];
    logic           cp_rdy [3];
    logic           rd_rdy [3];
    logic           err [3];
    logic [3:0]     nfree [3];

    // Instance g has NUM_BUF = 3 + g
    for (genvar g = 0; g < 3; g++) begin : g_dut
        dp_nbuf_rotating_buffer #(
            .COE_WIDTH(CW), .ADDR_WIDTH(AW), .NUM_LANE(NL), .NUM_BUF(3 + g), .RD_LATENCY(RL)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .i_flush(flush[g]),
            .i_wr_we(wr_we[g]), .i_wr_addr(wr_addr[g]), .i_wr_data(wr_data[g]),
            .i_wr_done(wr_done[g]), .o_wr_ready(wr_rdy[g]),
            .i_cp_we(cp_we[g]), .i_cp_wraddr(cp_wraddr[g]), .i_cp_data(cp_din[g]),
            .i_cp_rdaddr(cp_rdaddr[g]), .o_cp_data(cp_dout[g]),
            .i_cp_done(cp_done[g]), .o_cp_ready(cp_rdy[g]),
            .i_rd_addr(rd_addr[g]), .o_rd_data(rd_dout[g]),
            .i_rd_done(rd_done[g]), .o_rd_ready(rd_rdy[g]),
            .o_num_free(nfree[g]), .o_err(err[g])
        );
    end

    typedef struct {
        int         d;
        logic       fl, wd, cd, rdn;
        logic       e_wr, e_cp, e_rd;
        logic [3:0] e_free;
        logic       e_err;
    } vec_t;

    vec_t tv [NV];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int d, input logic fl, input logic wd, input logic cd, input logic rd);
        flush[d] = fl; wr_done[d] = wd; cp_done[d] = cd; rd_done[d] = rd;
        cyc();
        flush[d] = 1'b0; wr_done[d] = 1'b0; cp_done[d] = 1'b0; rd_done[d] = 1'b0;
    endtask

    task automatic wr_lane0(input int d, input int a, input logic [CW-1:0] v);
        wr_we[d] = 2'b01; wr_addr[d] = AWL'(a); wr_data[d] = DWL'(v);
        cyc();
        wr_we[d] = '0;
    endtask

    task automatic status(input int d, input string nm, input logic w, input logic c, input logic r,
                          input logic [3:0] f, input logic e);
        chk($sformatf("%s_wr_ready[nb%0d]", nm, d + 3), 64'(wr_rdy[d]), 64'(w));
        chk($sformatf("%s_cp_ready[nb%0d]", nm, d + 3), 64'(cp_rdy[d]), 64'(c));
        chk($sformatf("%s_rd_ready[nb%0d]", nm, d + 3), 64'(rd_rdy[d]), 64'(r));
        chk($sformatf("%s_num_free[nb%0d]", nm, d + 3), 64'(nfree[d]), 64'(f));
        chk($sformatf("%s_err[nb%0d]", nm, d + 3), 64'(err[d]), 64'(e));
    endtask

    initial begin
        //        d fl wd cd rd  wr cp rd free err
        tv = '{
            '{0, 0, 1, 0, 0, 1, 1, 0, 4'd2, 0},
            '{0, 0, 1, 0, 0, 1, 1, 0, 4'd1, 0},
            '{0, 0, 1, 0, 0, 0, 1, 0, 4'd0, 0},
            '{0, 0, 0, 1, 0, 0, 1, 1, 4'd0, 0},
            '{0, 0, 0, 0, 1, 1, 1, 0, 4'd1, 0},
            '{1, 0, 1, 0, 0, 1, 1, 0, 4'd3, 0},
            '{1, 0, 1, 1, 0, 1, 1, 1, 4'd2, 0},
            '{1, 0, 1, 1, 1, 1, 1, 1, 4'd2, 0},
            '{1, 0, 1, 1, 1, 1, 1, 1, 4'd2, 0},
            '{1, 0, 1, 1, 1, 1, 1, 1, 4'd2, 0},
            '{1, 1, 0, 0, 0, 1, 0, 0, 4'd4, 0},
            '{1, 0, 0, 1, 0, 1, 0, 0, 4'd4, 1},
            '{1, 0, 1, 0, 0, 1, 1, 0, 4'd3, 1},
            '{1, 1, 0, 0, 0, 1, 0, 0, 4'd4, 1},
            '{1, 0, 0, 0, 1, 1, 0, 0, 4'd4, 1},
            '{2, 1, 1, 1, 0, 1, 0, 0, 4'd5, 0},
            '{2, 0, 1, 0, 0, 1, 1, 0, 4'd4, 0},
            '{2, 1, 0, 0, 0, 1, 0, 0, 4'd5, 0}
        };
        for (int d = 0; d < 3; d++) begin
            flush[d] = 0; wr_done[d] = 0; cp_done[d] = 0; rd_done[d] = 0;
            wr_we[d] = '0; cp_we[d] = '0; wr_addr[d] = '0; cp_wraddr[d] = '0;
            cp_rdaddr[d] = '0; rd_addr[d] = '0; wr_data[d] = '0; cp_din[d] = '0;
        end
        cyc(); cyc();
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            status(d, "reset", 1, 0, 0, 4'(3 + d), 0);
            chk($sformatf("reset_cp_data[nb%0d]", d + 3), 64'(cp_dout[d][CW-1:0]), 0);
            chk($sformatf("reset_rd_data[nb%0d]", d + 3), 64'(rd_dout[d][CW-1:0]), 0);
        end

        for (int i = 0; i < NV; i++) begin
            pulse(tv[i].d, tv[i].fl, tv[i].wd, tv[i].cd, tv[i].rdn);
            status(tv[i].d, $sformatf("vec%0d", i), tv[i].e_wr, tv[i].e_cp, tv[i].e_rd, tv[i].e_free, tv[i].e_err);
        end

        // Three-buffer ring: latency, gated writer, old-buffer read at done, read-first, flush drop
        pulse(0, 1, 0, 0, 0);
        wr_lane0(0, 5, 39'h1234);
        pulse(0, 0, 1, 0, 0);
        cp_rdaddr[0] = AWL'(5);
        cyc();
        chk("cp_lat_early", 64'(cp_dout[0][CW-1:0]), 0);
        cyc();
        chk("cp_lat_data", 64'(cp_dout[0][CW-1:0]), 64'h1234);
        chk("rd_idle", 64'(rd_dout[0][CW-1:0]), 0);
        pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 1, 0, 0);
        status(0, "full", 0, 1, 0, 4'd0, 0);
        wr_lane0(0, 5, 39'hDEAD);
        cyc(); cyc();
        chk("gated_write", 64'(cp_dout[0][CW-1:0]), 64'h1234);
        pulse(0, 0, 0, 1, 0);
        cyc();
        chk("read_at_done_old_buf", 64'(cp_dout[0][CW-1:0]), 64'h1234);
        cp_we[0] = 2'b01; cp_wraddr[0] = AWL'(7); cp_din[0] = DWL'(39'h55);
        cyc();
        cp_din[0] = DWL'(39'h66); cp_rdaddr[0] = AWL'(7);
        cyc();
        cp_we[0] = '0;
        cyc();
        chk("read_first", 64'(cp_dout[0][CW-1:0]), 64'h55);
        cyc();
        chk("read_after_write", 64'(cp_dout[0][CW-1:0]), 64'h66);
        chk("rd_ready_computed", 64'(rd_rdy[0]), 1);
        rd_addr[0] = AWL'(5);
        cyc(); cyc();
        chk("rd_data", 64'(rd_dout[0][CW-1:0]), 64'h1234);
        flush[0] = 1'b1;
        cyc();
        flush[0] = 1'b0;
        chk("flush_drops_rd", 64'(rd_dout[0][CW-1:0]), 0);
        chk("flush_drops_cp", 64'(cp_dout[0][CW-1:0]), 0);
        status(0, "after_flush", 1, 0, 0, 4'd3, 0);
        cp_rdaddr[0] = '0; rd_addr[0] = '0;

        // Five-buffer ring: 12 full passes wrap every pointer twice, data tracked per pass
        for (int k = 0; k < 12; k++) begin
            wr_lane0(2, 3, 39'(32'h100 + k));
            pulse(2, 0, 1, 0, 0);
            chk($sformatf("pass%0d_cp_ready", k), 64'(cp_rdy[2]), 1);
            cp_rdaddr[2] = AWL'(3);
            cyc(); cyc();
            chk($sformatf("pass%0d_cp_data", k), 64'(cp_dout[2][CW-1:0]), 64'(32'h100 + k));
            cp_we[2] = 2'b01; cp_wraddr[2] = AWL'(3); cp_din[2] = DWL'(39'(32'h200 + k));
            cyc();
            cp_we[2] = '0;
            pulse(2, 0, 0, 1, 0);
            chk($sformatf("pass%0d_rd_ready", k), 64'(rd_rdy[2]), 1);
            rd_addr[2] = AWL'(3);
            cyc(); cyc();
            chk($sformatf("pass%0d_rd_data", k), 64'(rd_dout[2][CW-1:0]), 64'(32'h200 + k));
            pulse(2, 0, 0, 0, 1);
            chk($sformatf("pass%0d_wr_ready", k), 64'(wr_rdy[2]), 1);
            chk($sformatf("pass%0d_num_free", k), 64'(nfree[2]), 5);
        end
        chk("wrap_no_err", 64'(err[2]), 0);

        // Reset clears the sticky error that flush preserved
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) status(d, "final_reset", 1, 0, 0, 4'(3 + d), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dp_nbuf_rotating_buffer.md
Name: dp_nbuf_rotating_buffer

Overview:
- Parametrised successor to the fixed three-buffer ping-pong polyvec store.
- Holds NUM_BUF polyvec RAMs arranged as a ring, shared by three pipeline roles:
  - writer: AXI load.
  - compute: NTT read-modify-write.
  - reader: MADD/URAM drain.
- Each role advances independently with a ready/done handshake, rather than all roles rotating on one shared done. Extra buffers act as slack between unevenly paced stages.

Parameters:
- COE_WIDTH, 39, coefficient width.
- ADDR_WIDTH, 9, per-bank address width; depth is 1<<ADDR_WIDTH.
- NUM_LANE, 24, parallel banks per buffer (banks x polys).
- NUM_BUF, 4, number of buffers; legal range 3..8, need not be a power of 2.
- RD_LATENCY, 2, RAM read latency in cycles; must be >=1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_flush  in  1  synchronous soft clear of ring state
- i_wr_we  in  NUM_LANE  writer per-lane write enable
- i_wr_addr  in  ADDR_WIDTH*NUM_LANE  writer address
- i_wr_data  in  COE_WIDTH*NUM_LANE  writer data
- i_wr_done  in  1  writer finished current buffer (1-cycle pulse)
- o_wr_ready  out  1  writer owns a FREE buffer
- i_cp_we  in  NUM_LANE  compute write enable
- i_cp_wraddr  in  ADDR_WIDTH*NUM_LANE  compute write address
- i_cp_data  in  COE_WIDTH*NUM_LANE  compute write data
- i_cp_rdaddr  in  ADDR_WIDTH*NUM_LANE  compute read address
- o_cp_data  out  COE_WIDTH*NUM_LANE  compute read data
- i_cp_done  in  1  compute finished current buffer
- o_cp_ready  out  1  compute owns a FILLED buffer
- i_rd_addr  in  ADDR_WIDTH*NUM_LANE  reader address
- o_rd_data  out  COE_WIDTH*NUM_LANE  reader data
- i_rd_done  in  1  reader finished current buffer
- o_rd_ready  out  1  reader owns a COMPUTED buffer
- o_num_free  out  4  count of FREE buffers
- o_err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n=0 at edge), and also i_flush=1 with rst_n=1:
  - every buffer state = FREE; wr_ptr = cp_ptr = rd_ptr = 0.
  - o_wr_ready=1, o_cp_ready=0, o_rd_ready=0, o_num_free=NUM_BUF.
  - o_cp_data=0, o_rd_data=0, read-select pipelines cleared.
  - o_err cleared by rst_n only, not by i_flush. RAM contents are not cleared.
- Per-buffer state cycles FREE -> FILLED -> COMPUTED -> FREE.
- Ready outputs are combinational from registered state:
  - o_wr_ready = state[wr_ptr]==FREE.
  - o_cp_ready = state[cp_ptr]==FILLED.
  - o_rd_ready = state[rd_ptr]==COMPUTED.
- Accepted done: done pulse while the matching ready=1.
  - Next edge: buffer state advances one step and the role pointer increments.
  - Pointer wraps from NUM_BUF-1 to 0.
  - Ready reflects the new pointer from that cycle on.
- Ignored done: done while ready=0 changes no state or pointer and sets o_err=1.
- Simultaneous accepted dones always target distinct buffers and all take effect on the same edge. Ring order guarantees no role overtakes another.
- Port ownership:
  - Writer write port routes to buffer wr_ptr only while o_wr_ready=1; otherwise all enables are gated to 0.
  - Compute write/read ports route to buffer cp_ptr while o_cp_ready=1.
  - Reader read port routes to buffer rd_ptr while o_rd_ready=1.
  - A non-owned buffer sees we=0 and address 0.
- Read data:
  - Buffer select and valid for each reader role are captured at address time and delayed RD_LATENCY cycles.
  - o_cp_data / o_rd_data carry RAM dout of the delayed select, or 0 if the delayed valid=0.
  - Data for a read issued in the cycle of its done pulse is still delivered from the old buffer.
- RAM collisions:
  - Compute write and read to the same buffer and same address in the same cycle returns old data (read-first).
  - Each buffer has one write and one read port per lane; routing guarantees a single owner per port.
- o_num_free = number of FREE states, updated on the same edge as the state change.
- Reset or flush mid-operation discards in-flight reads: outputs are 0 the next cycle. Done pulses in the flush cycle are ignored without error.

Test Plan:
- NUM_BUF=3, reset, then wr_done pulse -> o_wr_ready=1 (buf1 FREE), o_cp_ready=1, o_num_free=2; repeat wr_done twice -> o_wr_ready=0, o_num_free=0.
- Writer writes 0x1234 at addr 5 lane 0, wr_done, compute reads addr 5 -> o_cp_data lane0 = 0x1234 exactly RD_LATENCY cycles later; o_rd_data stays 0.
- NUM_BUF=4, full pipeline: wr_done, cp_done, rd_done on the same cycle with all ready -> all three pointers advance together; o_num_free unchanged net; no o_err.
- cp_done with o_cp_ready=0 -> o_err=1, pointers unchanged; i_flush leaves o_err=1; rst_n clears it.
- NUM_BUF=5: cycle 12 buffers through all roles -> pointers wrap 4->0 correctly; data written in pass k read back intact in pass k.
- Writer asserts we while o_wr_ready=0 -> no RAM write: data previously in the target address is unchanged when later read.
